altr_hps_latch_bank: RTL and testbench

//  Clocked, multi-channel replacement for the single active-low transparent latch.
//  NUM_CH independent WIDTH-bit channels are held in flops on clk, so there is no timing loop.

---
 rtl/altr_hps_latch_bank.sv | 104 ++++++++++
 tb/tb_altr_hps_latch_bank.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/altr_hps_latch_bank.sv
// Clocked multi-channel replacement for an active-low transparent latch.
// Each channel adds a post-close lockout timer, a close pulse, a valid flag and a global freeze.
module altr_hps_latch_bank #(
  parameter int                WIDTH    = 8,
  parameter int                NUM_CH   = 4,
  parameter int                HOLD_CYC = 4,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*WIDTH-1:0]  d,
  input  logic [NUM_CH-1:0]        e_n,
  input  logic                     freeze,
  output logic [NUM_CH*WIDTH-1:0]  q,
  output logic [NUM_CH-1:0]        q_vld,
  output logic [NUM_CH-1:0]        close_pls,
  output logic [NUM_CH-1:0]        lock
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  // A close loads HOLD_CYC-1 so lock stays high for exactly HOLD_CYC cycles.
  localparam logic [CW-1:0] CNT_INIT = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

  typedef enum logic [1:0] {
    ST_HELD = 2'd0,
    ST_OPEN = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] q_r;
    logic             pls_r;
    logic             lock_r;
    logic             vld_r;
    logic [WIDTH-1:0] d_ch;

    assign d_ch = d[i*WIDTH +: WIDTH];

    // Per-channel FSM with registered q, pulse, lock and valid outputs; freeze holds everything.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r <= ST_HELD;
        cnt_r   <= '0;
        q_r     <= RST_VAL;
        pls_r   <= 1'b0;
        lock_r  <= 1'b0;
        vld_r   <= 1'b0;
      end else if (freeze) begin
        pls_r <= 1'b0;
      end else begin
        pls_r <= 1'b0;
        case (state_r)
          ST_HELD: begin
            if (!e_n[i]) begin
              state_r <= ST_OPEN;
              q_r     <= d_ch;
              vld_r   <= 1'b0;
              lock_r  <= 1'b0;
            end else begin
              state_r <= ST_HELD;
            end
          end
          ST_OPEN: begin
            if (!e_n[i]) begin
              q_r <= d_ch;
            end else begin
              pls_r <= 1'b1;
              vld_r <= 1'b1;
              if (HOLD_CYC > 0) begin
                state_r <= ST_LOCK;
                cnt_r   <= CNT_INIT;
                lock_r  <= 1'b1;
              end else begin
                state_r <= ST_HELD;
                lock_r  <= 1'b0;
              end
            end
          end
          ST_LOCK: begin
            if (cnt_r == '0) begin
              state_r <= ST_HELD;
              lock_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CW'(1);
            end
          end
          default: begin
            state_r <= ST_HELD;
            cnt_r   <= '0;
            lock_r  <= 1'b0;
          end
        endcase
      end
    end

    assign q[i*WIDTH +: WIDTH] = q_r;
    assign close_pls[i]        = pls_r;
    assign lock[i]             = lock_r;
    assign q_vld[i]            = vld_r;
  end

endmodule

// File: tb/tb_altr_hps_latch_bank.sv
// Directed self-checking bench for altr_hps_latch_bank (HOLD_CYC=4 and HOLD_CYC=0 builds).
module tb_altr_hps_latch_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d;
  logic [3:0]  e_n;
  logic [3:0]  z_e_n;
  logic        freeze;
  logic [31:0] q, zq;
  logic [3:0]  q_vld, close_pls, lock;
  logic [3:0]  zq_vld, zclose_pls, zlock;
  int checks   = 0;
  int failures = 0;

  altr_hps_latch_bank #(.WIDTH(8), .NUM_CH(4), .HOLD_CYC(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .e_n(e_n), .freeze(freeze),
    .q(q), .q_vld(q_vld), .close_pls(close_pls), .lock(lock)
  );

  altr_hps_latch_bank #(.WIDTH(8), .NUM_CH(4), .HOLD_CYC(0), .RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .d(d), .e_n(z_e_n), .freeze(freeze),
    .q(zq), .q_vld(zq_vld), .close_pls(zclose_pls), .lock(zlock)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freeze = 1'b1; e_n = 4'h0; z_e_n = 4'h0; d = 32'hDEADBEEF;
    tick(); tick();
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
    checks++; if (q_vld !== 4'h0) begin failures++; $display("FAIL reset_vld got=%h exp=%h", q_vld, 4'h0); end
    checks++; if (close_pls !== 4'h0) begin failures++; $display("FAIL reset_pls got=%h exp=%h", close_pls, 4'h0); end
    checks++; if (lock !== 4'h0) begin failures++; $display("FAIL reset_lock got=%h exp=%h", lock, 4'h0); end
    rst_n = 1'b1; freeze = 1'b0; e_n = 4'hF; z_e_n = 4'hF; d = 32'h0;
    tick();
  endtask

  task automatic test_follow();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    e_n[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[7:0] = vals[k];
      #1;
      if (k > 0) begin
        checks++; if (q[7:0] !== vals[k-1]) begin failures++; $display("FAIL follow_nocomb got=%h exp=%h", q[7:0], vals[k-1]); end
      end
      tick();
      checks++; if (q[7:0] !== vals[k]) begin failures++; $display("FAIL follow_q got=%h exp=%h", q[7:0], vals[k]); end
      checks++; if (q_vld[0] !== 1'b0) begin failures++; $display("FAIL follow_vld got=%b exp=0", q_vld[0]); end
    end
  endtask

  task automatic test_close();
    e_n[0] = 1'b1; d[7:0] = 8'h44;
    tick();
    checks++; if (q[7:0] !== 8'h33) begin failures++; $display("FAIL close_q got=%h exp=33", q[7:0]); end
    checks++; if (close_pls !== 4'h1) begin failures++; $display("FAIL close_pls got=%h exp=1", close_pls); end
    checks++; if (lock !== 4'h1) begin failures++; $display("FAIL close_lock got=%h exp=1", lock); end
    checks++; if (q_vld !== 4'h1) begin failures++; $display("FAIL close_vld got=%h exp=1", q_vld); end
    tick();
    checks++; if (close_pls[0] !== 1'b0) begin failures++; $display("FAIL close_pls_once got=%b exp=0", close_pls[0]); end
    checks++; if (lock[0] !== 1'b1) begin failures++; $display("FAIL close_lock2 got=%b exp=1", lock[0]); end
  endtask

  task automatic test_lock_ignore();
    e_n[0] = 1'b0; d[7:0] = 8'hAA;
    tick(); tick();
    checks++; if (q[7:0] !== 8'h33) begin failures++; $display("FAIL lockign_q got=%h exp=33", q[7:0]); end
    checks++; if (lock[0] !== 1'b1) begin failures++; $display("FAIL lockign_lock4 got=%b exp=1", lock[0]); end
    tick();
    checks++; if (lock[0] !== 1'b0) begin failures++; $display("FAIL lockign_drop got=%b exp=0", lock[0]); end
    checks++; if (q[7:0] !== 8'h33) begin failures++; $display("FAIL lockign_q2 got=%h exp=33", q[7:0]); end
    checks++; if (q_vld[0] !== 1'b1) begin failures++; $display("FAIL lockign_vld got=%b exp=1", q_vld[0]); end
    tick();
    checks++; if (q[7:0] !== 8'hAA) begin failures++; $display("FAIL reopen_q got=%h exp=aa", q[7:0]); end
    checks++; if (q_vld[0] !== 1'b0) begin failures++; $display("FAIL reopen_vld got=%b exp=0", q_vld[0]); end
  endtask

  task automatic test_freeze();
    e_n[0] = 1'b1;
    tick(); tick();
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e_n[0] = k[0];
      tick();
      checks++; if (lock[0] !== 1'b1) begin failures++; $display("FAIL frz_lock got=%b exp=1", lock[0]); end
      checks++; if (close_pls[0] !== 1'b0) begin failures++; $display("FAIL frz_pls got=%b exp=0", close_pls[0]); end
    end
    freeze = 1'b0; e_n[0] = 1'b1;
    tick(); tick();
    checks++; if (lock[0] !== 1'b1) begin failures++; $display("FAIL frz_ext got=%b exp=1", lock[0]); end
    tick();
    checks++; if (lock[0] !== 1'b0) begin failures++; $display("FAIL frz_end got=%b exp=0", lock[0]); end
    checks++; if (q[7:0] !== 8'hAA) begin failures++; $display("FAIL frz_q got=%h exp=aa", q[7:0]); end
    // Close on ch1 requested while frozen is taken on the first unfrozen edge.
    e_n[1] = 1'b0; d[15:8] = 8'h5A;
    tick();
    freeze = 1'b1; e_n[1] = 1'b1;
    tick(); tick();
    checks++; if (close_pls[1] !== 1'b0 || lock[1] !== 1'b0) begin failures++; $display("FAIL pend_hold got=%b%b exp=00", close_pls[1], lock[1]); end
    checks++; if (q[15:8] !== 8'h5A) begin failures++; $display("FAIL pend_q got=%h exp=5a", q[15:8]); end
    freeze = 1'b0;
    tick();
    checks++; if (close_pls !== 4'h2 || lock !== 4'h2) begin failures++; $display("FAIL pend_take got=%h/%h exp=2/2", close_pls, lock); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_simul_close_reset();
    e_n = 4'h0; d = 32'h44332211;
    tick();
    checks++; if (q !== 32'h44332211) begin failures++; $display("FAIL all_open_q got=%h exp=44332211", q); end
    e_n = 4'hF; d = 32'h0;
    tick();
    checks++; if (close_pls !== 4'hF) begin failures++; $display("FAIL all_pls got=%h exp=f", close_pls); end
    checks++; if (lock !== 4'hF || q_vld !== 4'hF) begin failures++; $display("FAIL all_lock_vld got=%h/%h exp=f/f", lock, q_vld); end
    tick();
    checks++; if (close_pls !== 4'h0) begin failures++; $display("FAIL all_pls_once got=%h exp=0", close_pls); end
    rst_n = 1'b0;
    tick();
    checks++; if (q !== 32'h0 || lock !== 4'h0 || q_vld !== 4'h0) begin failures++; $display("FAIL midlock_rst got=%h/%h/%h exp=0/0/0", q, lock, q_vld); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hold0();
    z_e_n[0] = 1'b0; d[7:0] = 8'hC3;
    tick();
    checks++; if (zq[7:0] !== 8'hC3 || zq_vld[0] !== 1'b0) begin failures++; $display("FAIL h0_open got=%h/%b exp=c3/0", zq[7:0], zq_vld[0]); end
    z_e_n[0] = 1'b1; d[7:0] = 8'h99;
    tick();
    checks++; if (zclose_pls !== 4'h1) begin failures++; $display("FAIL h0_pls got=%h exp=1", zclose_pls); end
    checks++; if (zlock !== 4'h0) begin failures++; $display("FAIL h0_lock got=%h exp=0", zlock); end
    checks++; if (zq[7:0] !== 8'hC3 || zq_vld[0] !== 1'b1) begin failures++; $display("FAIL h0_held got=%h/%b exp=c3/1", zq[7:0], zq_vld[0]); end
    z_e_n[0] = 1'b0; d[7:0] = 8'h3C;
    tick();
    checks++; if (zq[7:0] !== 8'h3C || zq_vld[0] !== 1'b0) begin failures++; $display("FAIL h0_reopen got=%h/%b exp=3c/0", zq[7:0], zq_vld[0]); end
    checks++; if (zclose_pls !== 4'h0 || zlock !== 4'h0) begin failures++; $display("FAIL h0_flags got=%h/%h exp=0/0", zclose_pls, zlock); end
  endtask

  initial begin
    test_reset();
    test_follow();
    test_close();
    test_lock_ignore();
    test_freeze();
    test_simul_close_reset();
    test_hold0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
